// File: rtl/clock_pkg.sv
// Shared definitions for the clock-enable controller: FSM encoding, mode value
// and the default divisor table.
package clock_pkg;

    localparam int MODE_W = 2;
    localparam logic [MODE_W-1:0] PROC_MODE_DEF = 2'b10;

    // Source 0 occupies the least significant field.
    localparam logic [77:0] DIV_LIST_DEF = {26'd50000000, 26'd2, 26'd5};

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_t;

endpackage

// File: rtl/clock_enable_control_if.sv
// Control/status bundle between a host and the clock-enable controller.
interface clock_enable_control_if
    import clock_pkg::*;
#(
    parameter int N_SRC = 4
);
    localparam int SEL_W = $clog2(N_SRC);

    logic [MODE_W-1:0] mode;
    logic [SEL_W-1:0]  sel;
    logic              manual;
    logic              halt;
    logic              clk_en;
    logic [SEL_W-1:0]  cur_sel;
    logic              switching;

    modport master (
        output mode, sel, manual, halt,
        input  clk_en, cur_sel, switching
    );

    modport slave (
        input  mode, sel, manual, halt,
        output clk_en, cur_sel, switching
    );

endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each filtered rising edge.
module button_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             filt_reg;
    logic             filt_d_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            filt_reg   <= 1'b0;
            filt_d_reg <= 1'b0;
            rise_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            // Any sample agreeing with the filtered level restarts the run.
            if (sync2_reg != filt_reg) begin
                if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
            filt_d_reg <= filt_reg;
            rise_reg   <= filt_reg & ~filt_d_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/clock_enable_control.sv
// Selects one of several clock-enable sources (shared-counter dividers or a
// debounced manual step) and switches between them without glitching clk_en.
module clock_enable_control
    import clock_pkg::*;
#(
    parameter int                         N_SRC      = 4,
    parameter int                         DIV_W      = 26,
    parameter logic [(N_SRC-1)*DIV_W-1:0] DIV_LIST   = DIV_LIST_DEF,
    parameter int                         DEB_CYCLES = 500000,
    parameter logic [MODE_W-1:0]          PROC_MODE  = PROC_MODE_DEF
) (
    input logic                   in_clock,
    input logic                   reset_n,
    clock_enable_control_if.slave bus
);
    localparam int               SEL_W   = $clog2(N_SRC);
    localparam logic [SEL_W-1:0] MAN_SEL = SEL_W'(N_SRC - 1);
    localparam logic [DIV_W-1:0] RST_CNT = DIV_LIST[DIV_W-1:0] - DIV_W'(1);

    state_t           state_reg;
    logic [SEL_W-1:0] cur_sel_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic             clk_en_reg;

    logic [SEL_W-1:0] req;
    logic             is_manual;
    logic             commit;
    logic             move;
    logic             deb_rise;
    logic [DIV_W-1:0] reload_tab [N_SRC];

    // The manual slot has no divisor; its reload value is never used for counting.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_reload
            if (gi < N_SRC - 1) begin : g_div
                assign reload_tab[gi] = DIV_LIST[gi*DIV_W +: DIV_W] - DIV_W'(1);
            end else begin : g_man
                assign reload_tab[gi] = '0;
            end
        end
    endgenerate

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (in_clock),
        .rst_n (reset_n),
        .raw   (bus.manual),
        .rise  (deb_rise)
    );

    always_comb begin
        req = '0;
        if (bus.mode == PROC_MODE && 32'(bus.sel) < N_SRC) begin
            req = bus.sel;
        end
        is_manual = (cur_sel_reg == MAN_SEL);
        // A divider source hands over only right after its own pulse.
        commit = (state_reg == ST_SWITCH) && (is_manual || clk_en_reg);
        move   = commit && (req != cur_sel_reg);
    end

    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_RUN;
            cur_sel_reg <= '0;
            cnt_reg     <= RST_CNT;
            clk_en_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN:    if (req != cur_sel_reg) state_reg <= ST_SWITCH;
                ST_SWITCH: if (commit) state_reg <= ST_RUN;
                default:   state_reg <= ST_RUN;
            endcase

            if (move) begin
                cur_sel_reg <= req;
                cnt_reg     <= reload_tab[req];
                clk_en_reg  <= 1'b0;
            end else if (is_manual) begin
                clk_en_reg <= deb_rise & ~bus.halt;
            end else if (bus.halt) begin
                clk_en_reg <= 1'b0;
            end else if (cnt_reg == '0) begin
                clk_en_reg <= 1'b1;
                cnt_reg    <= reload_tab[cur_sel_reg];
            end else begin
                clk_en_reg <= 1'b0;
                cnt_reg    <= cnt_reg - DIV_W'(1);
            end
        end
    end

    assign bus.clk_en    = clk_en_reg;
    assign bus.cur_sel   = cur_sel_reg;
    assign bus.switching = (state_reg == ST_SWITCH);

endmodule

// File: tb/tb_clock_enable_control.sv
// Directed bench: divisors {5,2,4}, 3-cycle debounce, manual source 3.
module tb_clock_enable_control;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    clock_enable_control_if #(.N_SRC(4)) bus ();

    clock_enable_control #(
        .N_SRC      (4),
        .DIV_W      (26),
        .DIV_LIST   ({26'd5, 26'd2, 26'd4}),
        .DEB_CYCLES (3),
        .PROC_MODE  (2'b10)
    ) dut (
        .in_clock (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
            $display("vec %0d %s = %0h", vectors, tag, obs);
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Steps n cycles; bit i of pat is the expected clk_en in the i-th cycle.
    task automatic train(input string tag, input int n, input logic [31:0] pat);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s[%0d]", tag, i), 32'(bus.clk_en), 32'(pat[i]));
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp_sel,
                             input logic exp_sw, input logic exp_en);
        chk({tag, "_cur_sel"},   32'(bus.cur_sel),   32'(exp_sel));
        chk({tag, "_switching"}, 32'(bus.switching), 32'(exp_sw));
        chk({tag, "_clk_en"},    32'(bus.clk_en),    32'(exp_en));
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.mode   = 2'b00;
        bus.sel    = 2'd0;
        bus.manual = 1'b0;
        bus.halt   = 1'b0;
        step();
        step();
        chk_state("reset", 2'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Source 0, divisor 4, mode 0.
        train("src0_run", 12, 32'h888);
        chk("src0_cur_sel", 32'(bus.cur_sel), 32'd0);

        // Switch 0 -> 1 mid-period.
        step();
        bus.mode = 2'b10;
        bus.sel  = 2'd1;
        step();
        chk_state("sw01_pend", 2'd0, 1'b1, 1'b0);
        step();
        chk_state("sw01_wait", 2'd0, 1'b1, 1'b0);
        step();
        chk_state("sw01_last", 2'd0, 1'b1, 1'b1);
        step();
        chk_state("sw01_commit", 2'd1, 1'b0, 1'b0);
        train("src1_run", 6, 32'b101010);

        // Switch 1 -> manual.
        bus.sel = 2'd3;
        step();
        chk_state("sw13_pend", 2'd1, 1'b1, 1'b0);
        step();
        chk_state("sw13_last", 2'd1, 1'b1, 1'b1);
        step();
        chk_state("sw13_commit", 2'd3, 1'b0, 1'b0);

        // Bounce 1-0-1, then hold: one pulse 6 cycles after the final edge.
        bus.manual = 1'b1;
        step();
        chk("bounce_hi", 32'(bus.clk_en), 32'd0);
        bus.manual = 1'b0;
        step();
        chk("bounce_lo", 32'(bus.clk_en), 32'd0);
        bus.manual = 1'b1;
        train("man_press", 12, 32'h40);
        bus.manual = 1'b0;
        train("man_release", 8, 32'h0);

        // Switch manual -> 2 commits on the following cycle.
        bus.sel = 2'd2;
        step();
        chk_state("sw32_pend", 2'd3, 1'b1, 1'b0);
        step();
        chk_state("sw32_commit", 2'd2, 1'b0, 1'b0);
        train("src2_run", 7, 32'h10);

        // Halt with two counts remaining, then resume.
        bus.halt = 1'b1;
        train("src2_halt", 10, 32'h0);
        chk("src2_halt_cur_sel", 32'(bus.cur_sel), 32'd2);
        bus.halt = 1'b0;
        train("src2_resume", 5, 32'h4);

        // Reset in the middle of a 2 -> 1 switch.
        bus.sel = 2'd1;
        step();
        chk_state("sw21_pend", 2'd2, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_state("mid_reset", 2'd0, 1'b0, 1'b0);
        step();
        chk_state("held_reset", 2'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        chk_state("post_rst_pend", 2'd0, 1'b1, 1'b0);
        train("post_rst_src0", 3, 32'b100);
        chk_state("post_rst_last", 2'd0, 1'b1, 1'b1);
        step();
        chk_state("post_rst_commit", 2'd1, 1'b0, 1'b0);
        train("post_rst_src1", 4, 32'b1010);

        // Back to source 0.
        bus.sel = 2'd0;
        step();
        chk("sw10_pend_switching", 32'(bus.switching), 32'd1);
        train("sw10", 2, 32'b01);
        chk_state("sw10_commit", 2'd0, 1'b0, 1'b0);
        train("src0_a", 4, 32'b1000);

        // Request 0 -> 1 -> 0 inside one period: no change, spacing kept.
        bus.sel = 2'd1;
        step();
        chk_state("glitch_pend", 2'd0, 1'b1, 1'b0);
        bus.sel = 2'd0;
        train("glitch", 3, 32'b100);
        chk_state("glitch_last", 2'd0, 1'b1, 1'b1);
        step();
        chk_state("glitch_done", 2'd0, 1'b0, 1'b0);
        train("src0_b", 7, 32'h44);

        // sel is ignored outside the processor mode.
        bus.mode = 2'b01;
        bus.sel  = 2'd2;
        step();
        chk("mode_ignore_sw", 32'(bus.switching), 32'd0);
        step();
        chk("mode_ignore_sel", 32'(bus.cur_sel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_enable_control.md
CLOCK_ENABLE_CONTROL -- requirements
Module: clock_enable_control

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of enable sources; sources 0..N_SRC-2 are dividers, source N_SRC-1 is manual step.
REQ-002 SHALL have parameter DIV_W, default 26: divider counter width.
REQ-003 SHALL have parameter DIV_LIST, default {26'd50000000, 26'd2, 26'd5} (source 0 in LSBs): packed (N_SRC-1)*DIV_W divisors, each >=1.
REQ-004 SHALL have parameter DEB_CYCLES, default 500000: cycles manual must be stable before acceptance.
REQ-005 SHALL have parameter PROC_MODE, default 2'b10: mode value enabling sel.
REQ-006 in_clock  input  1  single system clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 mode  input  2  operating mode; sel honoured only when mode==PROC_MODE.
REQ-009 sel  input  $clog2(N_SRC)  requested source.
REQ-010 manual  input  1  asynchronous push-button, active-high, bouncing.
REQ-011 halt  input  1  synchronous; freezes divider and suppresses clk_en.
REQ-012 clk_en  output  1  single-cycle enable pulse from active source.
REQ-013 cur_sel  output  $clog2(N_SRC)  currently active source.
REQ-014 switching  output  1  high while a source change is pending.

Function
REQ-015 Effective request SHALL be sel when mode==PROC_MODE, else 0; sel >= N_SRC SHALL map to 0.
REQ-016 Divider source k SHALL assert clk_en for one cycle every DIV_LIST[k] cycles; divisor 1 SHALL give clk_en high every cycle.
REQ-017 One shared down-counter SHALL serve all divider sources; it reloads DIV_LIST[cur_sel]-1 on reaching 0 (pulse cycle) and on every switch.
REQ-018 manual SHALL pass a 2-FF synchroniser, then a debounce counter; filtered level changes only after DEB_CYCLES consecutive equal synchronised samples.
REQ-019 When cur_sel==N_SRC-1, each filtered 0->1 transition SHALL yield exactly one clk_en pulse, 3+DEB_CYCLES cycles after the raw edge is sampled.
REQ-020 State machine states RUN, SWITCH: RUN->SWITCH when effective request != cur_sel; SWITCH->RUN on switch commit.
REQ-021 In SWITCH from a divider source, commit SHALL occur in the cycle after the current source's next clk_en; that pulse SHALL still be issued. No clk_en SHALL occur in the commit cycle.
REQ-022 In SWITCH from manual source, commit SHALL occur on the next cycle (no wait).
REQ-023 On commit, cur_sel takes the request value sampled at commit; if the request returned to cur_sel during SWITCH, return to RUN with no change and no counter reload.
REQ-024 switching SHALL equal (state==SWITCH).
REQ-025 halt high SHALL freeze the divider count and force clk_en low; a manual edge filtered during halt SHALL be discarded; switches still commit (REQ-021 waits indefinitely while halted).
REQ-026 The clock itself SHALL never be gated or muxed; only clk_en is produced.

Reset
REQ-027 Asserting reset_n low SHALL immediately force clk_en=0, cur_sel=0, switching=0, state RUN, counter=DIV_LIST[0]-1, synchroniser and debounce state = 0.
REQ-028 Reset mid-switch SHALL abandon the switch; after release, request is re-evaluated from RUN.
REQ-029 First clk_en after release with source 0 SHALL occur exactly DIV_LIST[0] cycles after the first active edge.

Structure
REQ-030 State encoding, PROC_MODE value and default DIV_LIST SHALL reside in shared package clock_pkg.
REQ-031 Debounce logic SHALL be sub-module button_debounce (synchroniser, counter, filtered-rising-edge pulse output), parameterised by DEB_CYCLES.

Verification (bench: DIV_LIST={26'd5,26'd2,26'd4}, DEB_CYCLES=3, N_SRC=4)
REQ-032 Reset release, mode=0 -> clk_en pulses at cycles 4, 8, 12 (source 0, divisor 4); cur_sel=0.
REQ-033 mode=2'b10, sel=1 mid-period -> switching high, pending source-0 pulse issued, commit next cycle, then pulses every 2 cycles; switching low after commit.
REQ-034 sel=3, manual bounces 1-0-1 then holds 1 for 5 cycles -> exactly one clk_en, 6 cycles after final rising edge sampled.
REQ-035 halt high for 10 cycles with source 2 -> no clk_en, counter frozen; first pulse after release completes the remaining count.
REQ-036 reset_n low during SWITCH -> outputs reset immediately; after release cur_sel=0, then a fresh switch to sel follows REQ-021.
REQ-037 sel 0->1->0 within one source-0 period -> no commit, no reload, source-0 pulse spacing unchanged.
